cpu_int_seq: RTL and testbench

Interrupt and reset sequencer for the 6502 core. It owns the register-file control lines during the reset vector fetch and during the NMI, IRQ and BRK entry sequences. For interrupts and BRK it pushes PCH, PCL and P onto page $01, fetches the 16-bit vector, and loads PC. It sits between the instruction decoder, the register file and the memory bus mux; while `busy` is high, the decoder yields the bus and register controls.

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/cpu_nmi_edge.sv | 36 +++
 rtl/cpu_int_seq.sv | 153 +++++++++++++++
 tb/tb_cpu_int_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 6502 interrupt/reset sequencer.
package cpu_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  // Sequencer states; reset lands in ST_RST_VL.
  typedef enum logic [3:0] {
    ST_RST_VL   = 4'd0,
    ST_RST_VH   = 4'd1,
    ST_IDLE     = 4'd2,
    ST_PUSH_PCH = 4'd3,
    ST_PUSH_PCL = 4'd4,
    ST_PUSH_P   = 4'd5,
    ST_VEC_LO   = 4'd6,
    ST_VEC_HI   = 4'd7,
    ST_LOAD     = 4'd8
  } int_state_t;

  // Default vector addresses.
  localparam logic [ADDR_W-1:0] VEC_NMI_DEF = 16'hFFFA;
  localparam logic [ADDR_W-1:0] VEC_RST_DEF = 16'hFFFC;
  localparam logic [ADDR_W-1:0] VEC_IRQ_DEF = 16'hFFFE;

  // Hardware stack lives in page $01.
  localparam logic [DATA_W-1:0] STACK_PAGE = 8'h01;

  // Status register bit positions.
  localparam int unsigned P_I = 2;
  localparam int unsigned P_B = 4;
  localparam int unsigned P_U = 5;

  // Status byte as written to the stack: U forced high, B reflects BRK.
  function automatic logic [DATA_W-1:0] push_status(input logic [DATA_W-1:0] p,
                                                    input logic              is_brk);
    logic [DATA_W-1:0] r;
    r      = p;
    r[P_U] = 1'b1;
    r[P_B] = is_brk;
    return r;
  endfunction

endpackage

// File: rtl/cpu_nmi_edge.sv
// NMI falling-edge detector with a sticky pending flag.
module cpu_nmi_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic nmi_n_i,
  input  logic clr_i,
  output logic pend_o
);

  logic prev_q;
  logic pend_q, pend_d;
  logic fall;

  assign fall = prev_q & ~nmi_n_i;

  // A new edge wins over a same-cycle clear so it is never lost.
  always_comb begin
    pend_d = pend_q;
    if (clr_i) pend_d = 1'b0;
    if (fall)  pend_d = 1'b1;
  end

  // Previous line value and pending flag; line idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b1;
      pend_q <= 1'b0;
    end else begin
      prev_q <= nmi_n_i;
      pend_q <= pend_d;
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/cpu_int_seq.sv
// Reset/NMI/IRQ/BRK entry sequencer: stacks PC and P, fetches a vector, loads PC.
module cpu_int_seq
  import cpu_pkg::*;
#(
  parameter logic [15:0] VEC_NMI = VEC_NMI_DEF,
  parameter logic [15:0] VEC_RST = VEC_RST_DEF,
  parameter logic [15:0] VEC_IRQ = VEC_IRQ_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        brk_req,
  input  logic        instr_boundary,
  input  logic        i_flag,
  input  logic [7:0]  p_in,
  input  logic [15:0] reg_pc,
  input  logic [7:0]  reg_sp,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        sp_push,
  output logic        reg_pc_write,
  output logic [15:0] pc_in,
  output logic        set_i,
  output logic        busy,
  output logic        seq_done
);

  int_state_t        state_q, state_d;
  logic              is_brk_q, is_brk_d;
  logic [7:0]        lo_q, lo_d;
  logic [15:0]       vec_q, vec_d;
  logic              nmi_pend;
  logic              nmi_clr;
  logic [15:0]       vec_sel;
  logic              irq_req;

  cpu_nmi_edge u_nmi_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .nmi_n_i (nmi_n),
    .clr_i   (nmi_clr),
    .pend_o  (nmi_pend)
  );

  assign irq_req = ~irq_n & ~i_flag;
  // A pending NMI overrides whatever request started the sequence.
  assign vec_sel = nmi_pend ? VEC_NMI : VEC_IRQ;

  // Next-state, B-bit capture, vector address and low-byte latches.
  always_comb begin
    state_d  = state_q;
    is_brk_d = is_brk_q;
    lo_d     = lo_q;
    vec_d    = vec_q;
    nmi_clr  = 1'b0;
    case (state_q)
      ST_RST_VL: state_d = ST_RST_VH;
      ST_RST_VH: begin
        lo_d    = mem_rdata;
        state_d = ST_LOAD;
      end
      ST_IDLE: begin
        if (instr_boundary) begin
          if (brk_req) begin
            is_brk_d = 1'b1;
            state_d  = ST_PUSH_PCH;
          end else if (nmi_pend || irq_req) begin
            is_brk_d = 1'b0;
            state_d  = ST_PUSH_PCH;
          end
        end
      end
      ST_PUSH_PCH: state_d = ST_PUSH_PCL;
      ST_PUSH_PCL: state_d = ST_PUSH_P;
      ST_PUSH_P:   state_d = ST_VEC_LO;
      ST_VEC_LO: begin
        vec_d   = vec_sel;
        nmi_clr = nmi_pend;
        state_d = ST_VEC_HI;
      end
      ST_VEC_HI: begin
        lo_d    = mem_rdata;
        state_d = ST_LOAD;
      end
      ST_LOAD: state_d = ST_IDLE;
      default: state_d = ST_RST_VL;
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RST_VL;
      is_brk_q <= 1'b0;
      lo_q     <= 8'h00;
      vec_q    <= 16'h0000;
    end else begin
      state_q  <= state_d;
      is_brk_q <= is_brk_d;
      lo_q     <= lo_d;
      vec_q    <= vec_d;
    end
  end

  // Bus and register-file controls decoded from state.
  always_comb begin
    mem_addr     = 16'h0000;
    mem_wdata    = 8'h00;
    mem_we       = 1'b0;
    sp_push      = 1'b0;
    reg_pc_write = 1'b0;
    pc_in        = 16'h0000;
    set_i        = 1'b0;
    seq_done     = 1'b0;
    case (state_q)
      ST_RST_VL: mem_addr = VEC_RST;
      ST_RST_VH: mem_addr = VEC_RST + 16'd1;
      ST_PUSH_PCH: begin
        mem_addr  = {STACK_PAGE, reg_sp};
        mem_wdata = reg_pc[15:8];
        mem_we    = 1'b1;
        sp_push   = 1'b1;
      end
      ST_PUSH_PCL: begin
        mem_addr  = {STACK_PAGE, reg_sp};
        mem_wdata = reg_pc[7:0];
        mem_we    = 1'b1;
        sp_push   = 1'b1;
      end
      ST_PUSH_P: begin
        mem_addr  = {STACK_PAGE, reg_sp};
        mem_wdata = push_status(p_in, is_brk_q);
        mem_we    = 1'b1;
        sp_push   = 1'b1;
      end
      ST_VEC_LO: mem_addr = vec_sel;
      ST_VEC_HI: mem_addr = vec_q + 16'd1;
      ST_LOAD: begin
        pc_in        = {mem_rdata, lo_q};
        reg_pc_write = 1'b1;
        set_i        = 1'b1;
        seq_done     = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cpu_int_seq.sv
// Directed bench for cpu_int_seq with a small memory and register-file model.
module tb_cpu_int_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        nmi_n;
  logic        irq_n;
  logic        brk_req;
  logic        instr_boundary;
  logic        i_flag;
  logic [7:0]  p_in;
  logic [15:0] reg_pc;
  logic [7:0]  reg_sp;
  logic [7:0]  mem_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        sp_push;
  logic        reg_pc_write;
  logic [15:0] pc_in;
  logic        set_i;
  logic        busy;
  logic        seq_done;

  logic [7:0]  mem [0:65535];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cpu_int_seq dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .nmi_n          (nmi_n),
    .irq_n          (irq_n),
    .brk_req        (brk_req),
    .instr_boundary (instr_boundary),
    .i_flag         (i_flag),
    .p_in           (p_in),
    .reg_pc         (reg_pc),
    .reg_sp         (reg_sp),
    .mem_rdata      (mem_rdata),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_we         (mem_we),
    .sp_push        (sp_push),
    .reg_pc_write   (reg_pc_write),
    .pc_in          (pc_in),
    .set_i          (set_i),
    .busy           (busy),
    .seq_done       (seq_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock from negedge to negedge; memory and register file react to the edge.
  task automatic step();
    logic [15:0] a;
    logic [7:0]  wd;
    logic [15:0] pci;
    logic        we, sp, pw, si;
    a = mem_addr; wd = mem_wdata; we = mem_we; sp = sp_push;
    pw = reg_pc_write; pci = pc_in; si = set_i;
    @(posedge clk);
    #1;
    if (we) mem[a] = wd;
    if (sp) reg_sp = reg_sp - 8'd1;
    if (pw) reg_pc = pci;
    if (si) i_flag = 1'b1;
    mem_rdata = mem[a];
    @(negedge clk);
  endtask

  // Called on the negedge right after rst_n is released.
  task automatic reset_seq();
    check("rst_c1_addr", 32'(mem_addr), 32'hFFFC);
    check("rst_c1_busy", 32'(busy), 32'h1);
    step();
    check("rst_c2_addr", 32'(mem_addr), 32'hFFFD);
    check("rst_c2_we", 32'(mem_we), 32'h0);
    step();
    check("rst_c3_pcw", 32'(reg_pc_write), 32'h1);
    check("rst_c3_pc_in", 32'(pc_in), 32'hC000);
    check("rst_c3_set_i", 32'(set_i), 32'h1);
    check("rst_c3_done", 32'(seq_done), 32'h1);
    step();
    check("rst_idle_busy", 32'(busy), 32'h0);
    check("rst_idle_done", 32'(seq_done), 32'h0);
    check("rst_pc", 32'(reg_pc), 32'hC000);
    check("rst_i_flag", 32'(i_flag), 32'h1);
  endtask

  // Called in the PUSH_PCH cycle; checks the whole entry sequence.
  task automatic do_entry(input logic [7:0] exp_p, input logic [15:0] ret_pc,
                          input logic [7:0] sp0, input logic [15:0] vec_addr,
                          input logic [15:0] exp_pc, input bit hijack);
    logic [7:0] sp1, sp2, sp3;
    sp1 = sp0 - 8'd1; sp2 = sp0 - 8'd2; sp3 = sp0 - 8'd3;
    check("pch_busy", 32'(busy), 32'h1);
    check("pch_addr", 32'(mem_addr), 32'({8'h01, sp0}));
    check("pch_data", 32'(mem_wdata), 32'(ret_pc[15:8]));
    check("pch_we", 32'(mem_we), 32'h1);
    check("pch_sp_push", 32'(sp_push), 32'h1);
    step();
    check("pcl_addr", 32'(mem_addr), 32'({8'h01, sp1}));
    check("pcl_data", 32'(mem_wdata), 32'(ret_pc[7:0]));
    check("pcl_sp_push", 32'(sp_push), 32'h1);
    if (hijack) nmi_n = 1'b0;
    step();
    check("p_addr", 32'(mem_addr), 32'({8'h01, sp2}));
    check("p_data", 32'(mem_wdata), 32'(exp_p));
    check("p_we", 32'(mem_we), 32'h1);
    step();
    check("veclo_addr", 32'(mem_addr), 32'(vec_addr));
    check("veclo_we", 32'(mem_we), 32'h0);
    check("veclo_sp_push", 32'(sp_push), 32'h0);
    step();
    check("vechi_addr", 32'(mem_addr), 32'(vec_addr + 16'd1));
    step();
    check("load_pcw", 32'(reg_pc_write), 32'h1);
    check("load_pc_in", 32'(pc_in), 32'(exp_pc));
    check("load_set_i", 32'(set_i), 32'h1);
    check("load_done", 32'(seq_done), 32'h1);
    step();
    check("end_busy", 32'(busy), 32'h0);
    check("end_addr", 32'(mem_addr), 32'h0);
    check("end_pc", 32'(reg_pc), 32'(exp_pc));
    check("end_sp", 32'(reg_sp), 32'(sp3));
    check("stk_pch", 32'(mem[{8'h01, sp0}]), 32'(ret_pc[15:8]));
    check("stk_pcl", 32'(mem[{8'h01, sp1}]), 32'(ret_pc[7:0]));
    check("stk_p", 32'(mem[{8'h01, sp2}]), 32'(exp_p));
  endtask

  initial begin
    rst_n = 1'b0; nmi_n = 1'b1; irq_n = 1'b1; brk_req = 1'b0;
    instr_boundary = 1'b0; i_flag = 1'b0; p_in = 8'h00;
    reg_pc = 16'h0000; reg_sp = 8'hFF; mem_rdata = 8'h00;
    mem[16'hFFFA] = 8'h00; mem[16'hFFFB] = 8'hA0;
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'hC0;
    mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'h90;
    repeat (2) @(negedge clk);

    // Values held during reset.
    check("rst_busy", 32'(busy), 32'h1);
    check("rst_addr", 32'(mem_addr), 32'hFFFC);
    check("rst_we", 32'(mem_we), 32'h0);
    check("rst_sp_push", 32'(sp_push), 32'h0);
    check("rst_pcw", 32'(reg_pc_write), 32'h0);
    check("rst_pc_in", 32'(pc_in), 32'h0);
    check("rst_done", 32'(seq_done), 32'h0);
    rst_n = 1'b1;
    reset_seq();

    // IRQ entry.
    reg_pc = 16'h1234; reg_sp = 8'hFF; p_in = 8'h00; i_flag = 1'b0;
    irq_n = 1'b0; instr_boundary = 1'b1;
    step();
    instr_boundary = 1'b0; irq_n = 1'b1;
    do_entry(8'h20, 16'h1234, 8'hFF, 16'hFFFE, 16'h9000, 1'b0);

    // Masked IRQ is ignored.
    irq_n = 1'b0; instr_boundary = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("irq_masked_busy", 32'(busy), 32'h0);
    end
    irq_n = 1'b1;

    // BRK entry: B bit set in pushed status.
    reg_pc = 16'h8002; p_in = 8'h00; brk_req = 1'b1;
    step();
    brk_req = 1'b0; instr_boundary = 1'b0;
    do_entry(8'h30, 16'h8002, 8'hFC, 16'hFFFE, 16'h9000, 1'b0);

    // NMI held low: one sequence only.
    reg_pc = 16'h4321; p_in = 8'hD3; instr_boundary = 1'b1; nmi_n = 1'b0;
    step();
    check("nmi_capture_idle", 32'(busy), 32'h0);
    step();
    do_entry(8'hE3, 16'h4321, 8'hF9, 16'hFFFA, 16'hA000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("nmi_held_busy", 32'(busy), 32'h0);
    end
    // New falling edge gives a second sequence.
    nmi_n = 1'b1;
    step();
    nmi_n = 1'b0;
    step();
    check("nmi2_capture_idle", 32'(busy), 32'h0);
    step();
    do_entry(8'hE3, 16'hA000, 8'hF6, 16'hFFFA, 16'hA000, 1'b0);
    nmi_n = 1'b1;
    step();

    // NMI during BRK push takes over the vector; B stays set.
    reg_pc = 16'h8102; p_in = 8'h00; brk_req = 1'b1; instr_boundary = 1'b1;
    step();
    brk_req = 1'b0;
    do_entry(8'h30, 16'h8102, 8'hF3, 16'hFFFA, 16'hA000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("hijack_no_follow", 32'(busy), 32'h0);
    end
    nmi_n = 1'b1;

    // Reset in PUSH_P aborts to the reset sequence.
    reg_pc = 16'h1234; i_flag = 1'b0; irq_n = 1'b0; instr_boundary = 1'b1;
    step();
    instr_boundary = 1'b0; irq_n = 1'b1;
    step();
    step();
    check("midrst_pre_we", 32'(mem_we), 32'h1);
    rst_n = 1'b0;
    #1;
    check("midrst_we", 32'(mem_we), 32'h0);
    check("midrst_busy", 32'(busy), 32'h1);
    check("midrst_addr", 32'(mem_addr), 32'hFFFC);
    check("midrst_sp_push", 32'(sp_push), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    i_flag = 1'b0;
    reset_seq();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
